datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL have port `Clock`, input, 1 bit: single clock; all register state updates on its rising edge.
REQ-002 SHALL have port `Clear`, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have ports `PCout`, `Zlowout`, `MDRout`, `R2out`, `R4out`, each input, 1 bit: bus-drive selects.
REQ-004 SHALL have ports `MARin`, `Zin`, `PCin`, `MDRin`, `IRin`, `Yin`, `R2in`, `R4in`, `R5in`, each input, 1 bit: register load enables.
REQ-005 SHALL have port `IncPC`, input, 1 bit: ALU op select, result = bus + 1.
REQ-006 SHALL have port `AND`, input, 1 bit: ALU op select, result = Y & bus.
REQ-007 SHALL have port `Read`, input, 1 bit: MDR input mux; 1 selects `Mdatain`, 0 selects the bus.
REQ-008 SHALL have port `Mdatain`, input, 32 bits: memory read data.
REQ-009 SHALL have port `BusMuxOut`, output, 32 bits: current internal bus value (combinational).
REQ-010 SHALL have ports `PC_q`, `IR_q`, `MAR_q`, `R2_q`, `R4_q`, `R5_q`, each output, 32 bits: register contents, for observation.

Function
REQ-011 SHALL contain 32-bit registers PC, IR, MAR, MDR, Y, R2, R4, R5, plus a 64-bit Z register (Zhigh:Zlow).
REQ-012 SHALL make the bus a combinational mux with fixed priority PCout > Zlowout > MDRout > R2out > R4out.
- Drives PC, Zlow, MDR, R2, R4 respectively.
- With no select asserted, SHALL drive bus = 0x00000000.
REQ-013 Each register with its `*in` high SHALL load the bus at the rising `Clock` edge; otherwise it SHALL hold.
- Exception: MDR loads the MDR mux output (REQ-007).
- Exception: Z loads the ALU result.
REQ-014 Load enables SHALL be independent: multiple registers MAY load the same bus value in one cycle.
REQ-015 SHALL compute the ALU result combinationally from Y and the bus; op priority:
- `AND` asserted → Zlow = Y & bus, Zhigh = 0.
- else `IncPC` asserted → Zlow = bus + 1 mod 2^32, Zhigh = 0.
- else → Zlow = Y + bus mod 2^32, Zhigh = carry-out in bit 0, other bits 0.
REQ-016 `Read` SHALL act only through the MDR mux; no other side effect.
REQ-017 Register latency SHALL be one edge: a value loaded at edge N is visible on the bus and outputs after edge N.
- A write and a read of the same register in one cycle SHALL read the old value.
REQ-018 PC wrap-around: PC = 0xFFFFFFFF with IncPC SHALL give Zlow = 0x00000000.

Reset
REQ-019 `Clear` = 0 SHALL immediately clear every register (PC, IR, MAR, MDR, Y, Z, R2, R4, R5) to 0, independent of `Clock`.
REQ-020 While `Clear` = 0, all load enables SHALL be ignored.
REQ-021 Reset asserted mid-sequence SHALL discard any in-progress load.
REQ-022 After reset, `BusMuxOut` SHALL follow REQ-012 (0 when no select is asserted).

Structure
REQ-023 Register widths (32, 64) and the bus-select priority encoding SHALL live in a shared package `datapath_pkg`.
REQ-024 SHALL use one sub-module, `datapath_reg32`: 32-bit register with async active-low clear and load enable, instantiated per register.
- Z SHALL be built from two instances.
- ALU and bus mux SHALL be inline logic.

Verification
REQ-025 Register load: Mdatain = 0x22, Read = MDRin = 1 for one edge, then MDRout = R2in = 1 for one edge → R2_q = 0x22.
- Repeat for R4 = 0x24 and R5 = 0x26.
REQ-026 Fetch: PC = 0 and PCout = MARin = IncPC = Zin = 1 for one edge → MAR_q = 0, Zlow = 1.
- Then Zlowout = PCin = Read = MDRin = 1 with Mdatain = 0x4A920000 → PC_q = 1.
- Then MDRout = IRin = 1 → IR_q = 0x4A920000.
REQ-027 AND: R2out = Yin = 1 for one edge; R4out = AND = Zin = 1 for one edge; Zlowout = R5in = 1 for one edge → R5_q = 0x22 & 0x24 = 0x20, R2_q and R4_q unchanged.
REQ-028 Bus priority: PCout and R2out both asserted → BusMuxOut = PC.
- No select asserted → BusMuxOut = 0.
REQ-029 Async reset: R5 = 0x26, drive `Clear` low between clock edges → R5_q = 0 before the next edge.
- Holding R5in high during reset → R5_q stays 0.
REQ-030 Wrap-around: PC = 0xFFFFFFFF, PCout = IncPC = Zin = 1 → Zlow = 0, Zhigh = 0.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared widths and bus-select encoding for the single-bus datapath.
package datapath_pkg;

    localparam int REG_W = 32;
    localparam int Z_W   = 64;

    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_PC   = 3'd1,
        SEL_ZLOW = 3'd2,
        SEL_MDR  = 3'd3,
        SEL_R2   = 3'd4,
        SEL_R4   = 3'd5
    } bus_sel_e;

    // Fixed priority: PC > Zlow > MDR > R2 > R4; nothing selected drives zero.
    function automatic bus_sel_e bus_select(input logic pc, input logic zlow,
                                            input logic mdr, input logic r2,
                                            input logic r4);
        if (pc)        return SEL_PC;
        else if (zlow) return SEL_ZLOW;
        else if (mdr)  return SEL_MDR;
        else if (r2)   return SEL_R2;
        else if (r4)   return SEL_R4;
        else           return SEL_NONE;
    endfunction

endpackage

// File: rtl/datapath_reg32.sv
// 32-bit register with asynchronous active-low clear and load enable.
module datapath_reg32
    import datapath_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [REG_W-1:0] d,
    output logic [REG_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/datapath.sv
// Single-bus datapath: register file on a priority bus mux, with a Y/Z ALU and an MDR memory mux.
module datapath
    import datapath_pkg::*;
(
    input  logic             Clock,
    input  logic             Clear,
    input  logic             PCout,
    input  logic             Zlowout,
    input  logic             MDRout,
    input  logic             R2out,
    input  logic             R4out,
    input  logic             MARin,
    input  logic             Zin,
    input  logic             PCin,
    input  logic             MDRin,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             R2in,
    input  logic             R4in,
    input  logic             R5in,
    input  logic             IncPC,
    input  logic             AND,
    input  logic             Read,
    input  logic [REG_W-1:0] Mdatain,
    output logic [REG_W-1:0] BusMuxOut,
    output logic [REG_W-1:0] PC_q,
    output logic [REG_W-1:0] IR_q,
    output logic [REG_W-1:0] MAR_q,
    output logic [REG_W-1:0] R2_q,
    output logic [REG_W-1:0] R4_q,
    output logic [REG_W-1:0] R5_q,
    output logic [Z_W-1:0]   Z_q
);

    logic [REG_W-1:0] mdr_q;
    logic [REG_W-1:0] y_q;
    logic [REG_W-1:0] zlow_q;
    logic [REG_W-1:0] zhigh_q;
    logic [REG_W-1:0] mdr_d;
    logic [REG_W-1:0] alu_lo;
    logic [REG_W-1:0] alu_hi;
    logic [REG_W:0]   sum;
    bus_sel_e         bus_sel;

    assign bus_sel = bus_select(PCout, Zlowout, MDRout, R2out, R4out);

    always_comb begin
        BusMuxOut = '0;
        case (bus_sel)
            SEL_PC:   BusMuxOut = PC_q;
            SEL_ZLOW: BusMuxOut = zlow_q;
            SEL_MDR:  BusMuxOut = mdr_q;
            SEL_R2:   BusMuxOut = R2_q;
            SEL_R4:   BusMuxOut = R4_q;
            default:  BusMuxOut = '0;
        endcase
    end

    assign mdr_d = Read ? Mdatain : BusMuxOut;

    // Add carries into bit 0 of Zhigh; AND and increment leave Zhigh clear.
    assign sum = {1'b0, y_q} + {1'b0, BusMuxOut};

    always_comb begin
        alu_lo = sum[REG_W-1:0];
        alu_hi = {{(REG_W-1){1'b0}}, sum[REG_W]};
        if (AND) begin
            alu_lo = y_q & BusMuxOut;
            alu_hi = '0;
        end else if (IncPC) begin
            alu_lo = BusMuxOut + 32'd1;
            alu_hi = '0;
        end
    end

    datapath_reg32 u_pc    (.clk(Clock), .rst_n(Clear), .en(PCin),  .d(BusMuxOut), .q(PC_q));
    datapath_reg32 u_ir    (.clk(Clock), .rst_n(Clear), .en(IRin),  .d(BusMuxOut), .q(IR_q));
    datapath_reg32 u_mar   (.clk(Clock), .rst_n(Clear), .en(MARin), .d(BusMuxOut), .q(MAR_q));
    datapath_reg32 u_mdr   (.clk(Clock), .rst_n(Clear), .en(MDRin), .d(mdr_d),     .q(mdr_q));
    datapath_reg32 u_y     (.clk(Clock), .rst_n(Clear), .en(Yin),   .d(BusMuxOut), .q(y_q));
    datapath_reg32 u_r2    (.clk(Clock), .rst_n(Clear), .en(R2in),  .d(BusMuxOut), .q(R2_q));
    datapath_reg32 u_r4    (.clk(Clock), .rst_n(Clear), .en(R4in),  .d(BusMuxOut), .q(R4_q));
    datapath_reg32 u_r5    (.clk(Clock), .rst_n(Clear), .en(R5in),  .d(BusMuxOut), .q(R5_q));
    datapath_reg32 u_zlow  (.clk(Clock), .rst_n(Clear), .en(Zin),   .d(alu_lo),    .q(zlow_q));
    datapath_reg32 u_zhigh (.clk(Clock), .rst_n(Clear), .en(Zin),   .d(alu_hi),    .q(zhigh_q));

    assign Z_q = {zhigh_q, zlow_q};

endmodule

// File: tb/tb_datapath.sv
// Directed bench for the datapath: control-word vector table plus carry, wrap and reset sequences.
module tb_datapath;

    typedef logic [16:0] ctrl_t;

    localparam ctrl_t C_PCOUT   = 17'h00001;
    localparam ctrl_t C_ZLOWOUT = 17'h00002;
    localparam ctrl_t C_MDROUT  = 17'h00004;
    localparam ctrl_t C_R2OUT   = 17'h00008;
    localparam ctrl_t C_R4OUT   = 17'h00010;
    localparam ctrl_t C_MARIN   = 17'h00020;
    localparam ctrl_t C_ZIN     = 17'h00040;
    localparam ctrl_t C_PCIN    = 17'h00080;
    localparam ctrl_t C_MDRIN   = 17'h00100;
    localparam ctrl_t C_IRIN    = 17'h00200;
    localparam ctrl_t C_YIN     = 17'h00400;
    localparam ctrl_t C_R2IN    = 17'h00800;
    localparam ctrl_t C_R4IN    = 17'h01000;
    localparam ctrl_t C_R5IN    = 17'h02000;
    localparam ctrl_t C_INCPC   = 17'h04000;
    localparam ctrl_t C_AND     = 17'h08000;
    localparam ctrl_t C_READ    = 17'h10000;

    typedef enum logic [2:0] {CHK_NONE, CHK_PC, CHK_IR, CHK_MAR, CHK_R2, CHK_R4, CHK_R5} chk_e;

    typedef struct {
        ctrl_t       c;
        logic [31:0] md;
        logic [31:0] exp_bus;
        chk_e        chk;
        logic [31:0] exp_val;
    } vec_t;

    logic        clock;
    logic        clear;
    logic        pc_out, zlow_out, mdr_out, r2_out, r4_out;
    logic        mar_in, z_in, pc_in, mdr_in, ir_in, y_in, r2_in, r4_in, r5_in;
    logic        inc_pc, and_op, read;
    logic [31:0] mdatain;
    logic [31:0] bus_mux_out, pc_q, ir_q, mar_q, r2_q, r4_q, r5_q;
    logic [63:0] z_q;

    logic [31:0] exp_q[$];
    int          n_checks;
    int          n_fail;
    vec_t        vecs[22];

    datapath dut (
        .Clock(clock), .Clear(clear),
        .PCout(pc_out), .Zlowout(zlow_out), .MDRout(mdr_out), .R2out(r2_out), .R4out(r4_out),
        .MARin(mar_in), .Zin(z_in), .PCin(pc_in), .MDRin(mdr_in), .IRin(ir_in), .Yin(y_in),
        .R2in(r2_in), .R4in(r4_in), .R5in(r5_in),
        .IncPC(inc_pc), .AND(and_op), .Read(read), .Mdatain(mdatain),
        .BusMuxOut(bus_mux_out), .PC_q(pc_q), .IR_q(ir_q), .MAR_q(mar_q),
        .R2_q(r2_q), .R4_q(r4_q), .R5_q(r5_q), .Z_q(z_q)
    );

    // Clock and watchdog
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input ctrl_t c, input logic [31:0] md, input logic [31:0] eb,
                                input chk_e chk, input logic [31:0] ev);
        vec_t v;
        v.c = c; v.md = md; v.exp_bus = eb; v.chk = chk; v.exp_val = ev;
        return v;
    endfunction

    function automatic logic [31:0] pick(input chk_e chk);
        case (chk)
            CHK_PC:  return pc_q;
            CHK_IR:  return ir_q;
            CHK_MAR: return mar_q;
            CHK_R2:  return r2_q;
            CHK_R4:  return r4_q;
            CHK_R5:  return r5_q;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input ctrl_t c, input logic [31:0] md);
        pc_out   = c[0];  zlow_out = c[1];  mdr_out = c[2];  r2_out = c[3];  r4_out = c[4];
        mar_in   = c[5];  z_in     = c[6];  pc_in   = c[7];  mdr_in = c[8];  ir_in  = c[9];
        y_in     = c[10]; r2_in    = c[11]; r4_in   = c[12]; r5_in  = c[13];
        inc_pc   = c[14]; and_op   = c[15]; read    = c[16];
        mdatain  = md;
    endtask

    task automatic step(input ctrl_t c, input logic [31:0] md);
        @(negedge clock);
        apply(c, md);
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        apply('0, 32'h0);

        vecs[0]  = mk(C_READ | C_MDRIN,                    32'h22,       32'h0,        CHK_NONE, 32'h0);
        vecs[1]  = mk(C_MDROUT | C_R2IN,                   32'h0,        32'h22,       CHK_R2,   32'h22);
        vecs[2]  = mk(C_READ | C_MDRIN,                    32'h24,       32'h0,        CHK_NONE, 32'h0);
        vecs[3]  = mk(C_MDROUT | C_R4IN,                   32'h0,        32'h24,       CHK_R4,   32'h24);
        vecs[4]  = mk(C_READ | C_MDRIN,                    32'h26,       32'h0,        CHK_NONE, 32'h0);
        vecs[5]  = mk(C_MDROUT | C_R5IN,                   32'h0,        32'h26,       CHK_R5,   32'h26);
        vecs[6]  = mk(C_PCOUT | C_MARIN | C_INCPC | C_ZIN, 32'h0,        32'h0,        CHK_MAR,  32'h0);
        vecs[7]  = mk(C_ZLOWOUT | C_PCIN | C_READ | C_MDRIN, 32'h4A920000, 32'h1,      CHK_PC,   32'h1);
        vecs[8]  = mk(C_MDROUT | C_IRIN,                   32'h0,        32'h4A920000, CHK_IR,   32'h4A920000);
        vecs[9]  = mk(C_R2OUT | C_YIN,                     32'h0,        32'h22,       CHK_R2,   32'h22);
        vecs[10] = mk(C_R4OUT | C_AND | C_ZIN,             32'h0,        32'h24,       CHK_R4,   32'h24);
        vecs[11] = mk(C_ZLOWOUT | C_R5IN,                  32'h0,        32'h20,       CHK_R5,   32'h20);
        vecs[12] = mk(C_R2OUT | C_YIN,                     32'h0,        32'h22,       CHK_R2,   32'h22);
        vecs[13] = mk(C_R4OUT | C_ZIN,                     32'h0,        32'h24,       CHK_R4,   32'h24);
        vecs[14] = mk(C_ZLOWOUT | C_R2IN,                  32'h0,        32'h46,       CHK_R2,   32'h46);
        vecs[15] = mk(C_ZLOWOUT | C_ZIN | C_INCPC,         32'h0,        32'h46,       CHK_NONE, 32'h0);
        vecs[16] = mk(C_ZLOWOUT | C_R4IN,                  32'h0,        32'h47,       CHK_R4,   32'h47);
        vecs[17] = mk(C_MDROUT | C_R4IN | C_R5IN,          32'h0,        32'h4A920000, CHK_R5,   32'h4A920000);
        vecs[18] = mk(C_R4OUT,                             32'h0,        32'h4A920000, CHK_R4,   32'h4A920000);
        vecs[19] = mk(C_PCOUT | C_R2OUT,                   32'h0,        32'h1,        CHK_R2,   32'h46);
        vecs[20] = mk('0,                                  32'h0,        32'h0,        CHK_PC,   32'h1);
        vecs[21] = mk(C_ZLOWOUT | C_R4OUT,                 32'h0,        32'h47,       CHK_NONE, 32'h0);

        // Reset block: pulse Clear low and check every observable register
        clear = 1'b1;
        #1 clear = 1'b0;
        #2;
        check("reset_bus", 64'(bus_mux_out), 64'h0);
        check("reset_pc",  64'(pc_q),  64'h0);
        check("reset_ir",  64'(ir_q),  64'h0);
        check("reset_mar", 64'(mar_q), 64'h0);
        check("reset_r2",  64'(r2_q),  64'h0);
        check("reset_r4",  64'(r4_q),  64'h0);
        check("reset_r5",  64'(r5_q),  64'h0);
        check("reset_z",   z_q,        64'h0);
        @(negedge clock);
        clear = 1'b1;

        for (int i = 0; i < 22; i++) begin
            @(negedge clock);
            apply(vecs[i].c, vecs[i].md);
            #2;
            check($sformatf("vec%0d_bus", i), 64'(bus_mux_out), 64'(vecs[i].exp_bus));
            if (vecs[i].chk != CHK_NONE) exp_q.push_back(vecs[i].exp_val);
            @(posedge clock);
            #1;
            if (vecs[i].chk != CHK_NONE) begin
                check($sformatf("vec%0d_%s", i, vecs[i].chk.name()), 64'(pick(vecs[i].chk)),
                      64'(exp_q.pop_front()));
            end
        end

        // Add with carry-out lands in Zhigh bit 0
        step(C_READ | C_MDRIN, 32'hFFFFFFFF);
        step(C_MDROUT | C_YIN, 32'h0);
        step(C_MDROUT | C_ZIN, 32'h0);
        check("add_carry_z", z_q, 64'h00000001_FFFFFFFE);

        // PC wrap-around through IncPC
        step(C_MDROUT | C_PCIN, 32'h0);
        check("wrap_pc", 64'(pc_q), 64'hFFFFFFFF);
        @(negedge clock);
        apply(C_PCOUT | C_INCPC | C_ZIN, 32'h0);
        #2;
        check("wrap_bus", 64'(bus_mux_out), 64'hFFFFFFFF);
        @(posedge clock);
        #1;
        check("wrap_z", z_q, 64'h0);
        step(C_ZLOWOUT, 32'h0);
        check("wrap_zlow_bus", 64'(bus_mux_out), 64'h0);

        // Asynchronous clear between edges, with loads held active
        step(C_READ | C_MDRIN, 32'h26);
        step(C_MDROUT | C_R5IN, 32'h0);
        check("pre_clear_r5", 64'(r5_q), 64'h26);
        @(negedge clock);
        apply(C_MDROUT | C_R5IN | C_PCIN | C_IRIN | C_ZIN, 32'h0);
        #2;
        clear = 1'b0;
        #1;
        check("clear_r5_async", 64'(r5_q), 64'h0);
        check("clear_pc_async", 64'(pc_q), 64'h0);
        check("clear_ir_async", 64'(ir_q), 64'h0);
        check("clear_bus",      64'(bus_mux_out), 64'h0);
        @(posedge clock);
        #1;
        check("clear_hold_r5", 64'(r5_q), 64'h0);
        check("clear_hold_z",  z_q,       64'h0);
        @(negedge clock);
        apply('0, 32'h0);
        clear = 1'b1;
        #2;
        check("post_clear_bus", 64'(bus_mux_out), 64'h0);
        check("post_clear_r2",  64'(r2_q), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
